// File: rtl/stream_in.sv
// stream_in: packs eight 16-bit words into one 128-bit block, word 0 in dout[15:0].
// Latency: dout/tout update and vout pulses in the cycle after the edge that accepts word 7.
// Backpressure: none; a word is taken on every cycle vin is high, sustaining one word per cycle.
module stream_in #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vin,
    input  logic         sin,
    input  logic         tin,
    input  logic [15:0]  din,
    output logic         vout,
    output logic         tout,
    output logic [127:0] dout,
    output logic         err
);
    // Idle counter only needs to reach TIMEOUT; a zero TIMEOUT keeps it pinned at 0.
    localparam int            IW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
    localparam bit            TMO_EN   = (TIMEOUT != 0);

    logic [2:0]       cnt_q;
    logic [2:0]       cnt_d;
    logic [IW-1:0]    idle_q;
    logic [IW-1:0]    idle_d;
    logic [7:0][15:0] asm_q;
    logic             typ_q;

    logic             tmo;
    logic             restart;
    logic             take_first;
    logic             done;
    logic [7:0][15:0] blk;

    // Classify the current cycle: timeout, forced restart, word 0, or block completion.
    always_comb begin
        tmo        = TMO_EN && (cnt_q != 3'd0) && (idle_q == IDLE_MAX);
        restart    = vin && sin && (cnt_q != 3'd0);
        // A word arriving alongside a timeout or restart opens the next block.
        take_first = vin && ((cnt_q == 3'd0) || restart || tmo);
        done       = vin && !sin && (cnt_q == 3'd7) && !tmo;
    end

    // Next word index and idle count.
    always_comb begin
        cnt_d  = cnt_q;
        idle_d = idle_q;
        if (take_first) begin
            cnt_d = 3'd1;
        end else if (vin) begin
            cnt_d = cnt_q + 3'd1;          // wraps 7 -> 0 on completion
        end else if (tmo) begin
            cnt_d = 3'd0;
        end

        if (vin || (cnt_q == 3'd0)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Completed block: the seven stored words plus the word arriving now as word 7.
    always_comb begin
        blk    = asm_q;
        blk[7] = din;
    end

    // Assembly state: word index, idle count, partial block and its captured type.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 3'd0;
            idle_q <= '0;
            asm_q  <= '0;
            typ_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            if (take_first) begin
                asm_q[0] <= din;
                typ_q    <= tin;
            end else if (vin) begin
                asm_q[cnt_q] <= din;
            end
        end
    end

    // Output register: loads only on completion so discarded partials never reach dout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vout <= 1'b0;
            err  <= 1'b0;
            tout <= 1'b0;
            dout <= '0;
        end else begin
            vout <= done;
            err  <= restart || tmo;
            if (done) begin
                dout <= blk;
                tout <= typ_q;
            end
        end
    end

endmodule
